// File: rtl/common.sv
// Shared execute-stage types: shift descriptor produced by decode and the
// state encoding of the iterative shift unit.
package common;

    typedef enum logic [2:0] {
        SHIFT_SHL     = 3'd0,
        SHIFT_SHR     = 3'd1,
        SHIFT_ASL     = 3'd2,
        SHIFT_ASR     = 3'd3,
        SHIFT_ROL     = 3'd4,
        SHIFT_ROR     = 3'd5,
        SHIFT_INVALID = 3'd6
    } e_shift_type;

    typedef struct packed {
        e_shift_type shift_type;
        logic [4:0]  amount;
    } s_shift;

    typedef enum bit [1:0] {SHX_IDLE, SHX_BUSY, SHX_DONE} e_shift_exec_state;

    localparam int SHIFT_EXEC_WIDTH = 32;

    // Code 7 is never produced by decode but must still be flagged as an error.
    function automatic logic shift_type_invalid(input logic [2:0] code);
        return (code >= 3'd6);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of the iterative shifter: moves the working value
// by one bit, or by four bits when by4 is set.
module shift_step
    import common::*;
#(
    parameter int WIDTH = SHIFT_EXEC_WIDTH
) (
    input  e_shift_type      kind,
    input  logic [WIDTH-1:0] value,
    input  logic             by4,
    output logic [WIDTH-1:0] result
);

    // Select the stepped value for the latched shift type; unknown codes pass through.
    always_comb begin
        result = value;
        if (by4) begin
            case (kind)
                SHIFT_SHL, SHIFT_ASL: result = {value[WIDTH-5:0], 4'b0000};
                SHIFT_SHR:            result = {4'b0000, value[WIDTH-1:4]};
                SHIFT_ASR:            result = {{4{value[WIDTH-1]}}, value[WIDTH-1:4]};
                SHIFT_ROL:            result = {value[WIDTH-5:0], value[WIDTH-1:WIDTH-4]};
                SHIFT_ROR:            result = {value[3:0], value[WIDTH-1:4]};
                default:              result = value;
            endcase
        end else begin
            case (kind)
                SHIFT_SHL, SHIFT_ASL: result = {value[WIDTH-2:0], 1'b0};
                SHIFT_SHR:            result = {1'b0, value[WIDTH-1:1]};
                SHIFT_ASR:            result = {value[WIDTH-1], value[WIDTH-1:1]};
                SHIFT_ROL:            result = {value[WIDTH-2:0], value[WIDTH-1]};
                SHIFT_ROR:            result = {value[0], value[WIDTH-1:1]};
                default:              result = value;
            endcase
        end
    end

endmodule

// File: rtl/shift_exec.sv
// Iterative shift execution unit with valid/ready on both sides.
// Define SHIFT_EXEC_STEP4_EN to step four bits per cycle while at least four remain.
module shift_exec
    import common::*;
#(
    parameter int WIDTH = SHIFT_EXEC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  s_shift           in_shift,
    input  logic [WIDTH-1:0] in_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err
);

    e_shift_exec_state state_q, state_d;
    e_shift_type       kind_q, kind_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [4:0]        rem_q, rem_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              by4_s;
    logic [4:0]        step_dec_s;
    logic [WIDTH-1:0]  stepped_s;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .kind   (kind_q),
        .value  (work_q),
        .by4    (by4_s),
        .result (stepped_s)
    );

    // Step size for the current BUSY cycle.
    always_comb begin
`ifdef SHIFT_EXEC_STEP4_EN
        if (rem_q >= 5'd4) begin
            by4_s = 1'b1;
        end else begin
            by4_s = 1'b0;
        end
`else
        by4_s = 1'b0;
`endif
        step_dec_s = by4_s ? 5'd4 : 5'd1;
    end

    // Next-state logic: accept in IDLE, step in BUSY, hold until handoff in DONE.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        work_d  = work_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            SHX_IDLE: begin
                if (in_valid) begin
                    kind_d = in_shift.shift_type;
                    work_d = in_operand;
                    rem_d  = in_shift.amount;
                    if (shift_type_invalid(in_shift.shift_type)) begin
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = SHX_DONE;
                    end else if (in_shift.amount == 5'd0) begin
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = SHX_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SHX_BUSY;
                    end
                end else begin
                    state_d = SHX_IDLE;
                end
            end
            SHX_BUSY: begin
                work_d = stepped_s;
                rem_d  = rem_q - step_dec_s;
                if (rem_q == step_dec_s) begin
                    valid_d = 1'b1;
                    state_d = SHX_DONE;
                end else begin
                    state_d = SHX_BUSY;
                end
            end
            SHX_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = SHX_IDLE;
                end else begin
                    state_d = SHX_DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                err_d   = 1'b0;
                state_d = SHX_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SHX_IDLE;
            kind_q  <= SHIFT_SHL;
            work_q  <= {WIDTH{1'b0}};
            rem_q   <= 5'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == SHX_IDLE);
    assign out_valid  = valid_q;
    assign out_result = work_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_shift_exec.sv
// Directed self-checking bench for shift_exec (default or SHIFT_EXEC_STEP4_EN build).
module tb_shift_exec;
    import common::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    s_shift      in_shift;
    logic [31:0] in_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    shift_exec dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_shift   (in_shift),
        .in_operand (in_operand),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int n);
`ifdef SHIFT_EXEC_STEP4_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] code, input logic [4:0] amt, input logic [31:0] opnd);
        in_shift   = s_shift'({code, amt});
        in_operand = opnd;
    endtask

    // Count edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] code, input logic [4:0] amt,
                       input logic [31:0] opnd, input logic [31:0] exp_res,
                       input logic exp_err, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        set_req(code, amt, opnd);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_req(3'd0, 5'd0, 32'h0);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, out_result, exp_res);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        check({tag, "_handoff"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_shift   = s_shift'(8'h00);
        in_operand = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_ready",  {31'd0, in_ready},  32'd1);
        check("rst_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_result", out_result,         32'd0);
        check("rst_err",    {31'd0, out_err},   32'd0);

        run("rol1",   3'd4, 5'd1,  32'h8000_0001, 32'h0000_0003, 1'b0, lat_of(1));
        run("asr4",   3'd3, 5'd4,  32'hF000_0000, 32'hFF00_0000, 1'b0, lat_of(4));
        run("shr31",  3'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, lat_of(31));
        run("shl0",   3'd0, 5'd0,  32'h0000_1234, 32'h0000_1234, 1'b0, 0);
        run("asl1",   3'd2, 5'd1,  32'h4000_0000, 32'h8000_0000, 1'b0, lat_of(1));
        run("inv6",   3'd6, 5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0);
        run("inv7",   3'd7, 5'd9,  32'h1357_9BDF, 32'h1357_9BDF, 1'b1, 0);
        run("rol7",   3'd4, 5'd7,  32'h1234_5678, 32'h1A2B_3C09, 1'b0, lat_of(7));
        run("asr_pos",3'd3, 5'd6,  32'h7FFF_FFC0, 32'h01FF_FFFF, 1'b0, lat_of(6));
        run("ror9",   3'd5, 5'd9,  32'h0000_01FF, 32'hFF80_0000, 1'b0, lat_of(9));

        // Backpressure: result held, second request waits until after handoff.
        out_ready = 1'b0;
        set_req(3'd5, 5'd1, 32'h0000_0001);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_req(3'd0, 5'd2, 32'h0000_0001);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'(lat_of(1)));
        for (int i = 0; i < 5; i++) begin
            check("bp_res",   out_result,             32'h8000_0000);
            check("bp_hold",  {30'd0, out_valid, in_ready}, 32'd2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handoff", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_accept2", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp2_lat", 32'(lat), 32'(lat_of(2)));
        check("bp2_res", out_result, 32'h0000_0004);
        @(posedge clk); #1;

        // Reset in the middle of a long shift.
        set_req(3'd1, 5'd20, 32'hFFFF_0000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", {30'd0, out_valid, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_flags",  {29'd0, out_valid, out_err, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        run("post_rst_shl2", 3'd0, 5'd2, 32'h0000_0001, 32'h0000_0004, 1'b0, lat_of(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_exec.md
# shift_exec

Multi-cycle shift execution unit that consumes an `s_shift` descriptor from package `common` together with a 32-bit operand and produces the shifted result. It is the consumer end of the descriptor: decode fills `s_shift`, and `shift_exec` carries it out. It sits in the execute stage beside the ALU and uses valid/ready handshakes on both sides. It is iterative, stepping one bit per cycle, so it costs little area compared with a barrel shifter.

## Interface
- Parameters:
  - `WIDTH`, default 32: operand width. Must equal 2^bits(`s_shift.amount`), i.e. 32.
- Ports:
  - `clk`, in, 1: clock. Single clock domain.
  - `reset`, in, 1: asynchronous, active-high reset.
  - `in_valid`, in, 1: request valid.
  - `in_ready`, out, 1: unit can accept a request.
  - `in_shift`, in, `s_shift`: shift type and amount (0–31).
  - `in_operand`, in, WIDTH: value to shift.
  - `out_valid`, out, 1: result valid.
  - `out_ready`, in, 1: consumer accepts the result.
  - `out_result`, out, WIDTH: shifted value.
  - `out_err`, out, 1: type code was `SHIFT_INVALID` or the unused code 7.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - BUSY: stepping.
  - DONE: `out_valid`=1.
- Accept occurs on a rising edge with `in_valid && in_ready`. On accept:
  - Latch the operand into the working register and latch the type.
  - `remaining` = amount.
- From accept, the next state is chosen as follows:
  - Invalid type: go to DONE with `out_err`=1 and the result equal to the operand unmodified.
  - Amount 0: go to DONE.
  - Otherwise: go to BUSY.
- BUSY, each edge: apply one step to the working register and decrement `remaining`. When `remaining` reaches 0, go to DONE.
- Step semantics, with the 1-bit step and MSB = bit WIDTH-1:
  - SHL: `{w[W-2:0],0}`.
  - SHR: `{0,w[W-1:1]}`.
  - ASL: identical to SHL.
  - ASR: `{w[W-1],w[W-1:1]}`.
  - ROL: `{w[W-2:0],w[W-1]}`.
  - ROR: `{w[0],w[W-1:1]}`.
- DONE: `out_result` and `out_err` are held stable until `out_valid && out_ready` on an edge, then the state returns to IDLE.
- `in_ready` is 1 only in IDLE. There is no accept in the same cycle as result handoff.
- `in_shift`/`in_operand` are sampled only at accept. Later changes are ignored.
- Reset, including mid-operation, asynchronously forces:
  - state IDLE;
  - `out_valid`=0, `out_err`=0, `out_result`=0;
  - `in_ready`=1 once reset deasserts.
- Any in-flight request is discarded.

## Timing
- Let E0 be the accepting edge. `out_valid` first rises after edge E_n, where n = amount:
  - amount 0 or invalid type: the cycle right after E0;
  - amount 31: after E31.
- All outputs are registered. No combinational path from inputs to outputs, except that `in_ready` is a decode of the state register.
- Minimum request-to-request spacing is n+2 cycles when `out_ready` is held high.

## Configuration
- `SHIFT_EXEC_STEP4_EN` defined:
  - Each BUSY edge steps by 4 while `remaining` ≥ 4, otherwise by 1.
  - Edge count is floor(n/4) + n mod 4. Example: n=31 yields DONE after E10.
  - Results are bit-identical to the 1-step version.
- Not defined: 1-bit step only, with the latency given in Timing.

## Structure
- `e_shift_type` and `s_shift` stay in package `common`.
- Add to `common`:
  - `typedef enum bit[1:0] {SHX_IDLE, SHX_BUSY, SHX_DONE} e_shift_exec_state`;
  - `localparam SHIFT_EXEC_WIDTH = 32`.
- Sub-module `shift_step`: purely combinational. Inputs are type, value, and a 1-bit `by4` select; output is the stepped value. It is instantiated once in `shift_exec`.

## Test plan
- ROL `0x80000001` by 1, `out_ready`=1 → `out_result`=`0x00000003`, `out_err`=0, `out_valid` after E1.
- ASR `0xF0000000` by 4 → `0xFF000000`. SHR `0x80000000` by 31 → `0x00000001`, `out_valid` after E31, or after E10 with `SHIFT_EXEC_STEP4_EN`.
- SHL `0x00001234` by 0 → `0x00001234` in the cycle after E0. ASL `0x40000000` by 1 → `0x80000000`.
- Type code 6 with operand `0xDEADBEEF` by 5 → `out_err`=1, `out_result`=`0xDEADBEEF`, `out_valid` after E0.
- ROR `0x00000001` by 1 with `out_ready`=0 for 5 cycles → `0x80000000` held stable, `in_ready`=0 throughout, and a second `in_valid` is not accepted until one cycle after handoff.
- Assert `reset` at BUSY cycle 3 of SHR by 20 → immediately IDLE with all outputs 0. A fresh SHL `0x1` by 2 afterwards → `0x4`.
